// File: rtl/sar_pkg.sv
// Shared types and helpers for the 12-bit SAR controller.
package sar_pkg;

    localparam int unsigned NBITS_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        SAMP,
        SETTLE,
        COMPARE,
        DONE1,
        DONE2
    } sar_state_t;

    // First trial code of a binary search: only the MSB set.
    function automatic logic [31:0] midscale(input int unsigned nbits);
        return 32'(1) << (nbits - 1);
    endfunction

endpackage

// File: rtl/sar_step_reg.sv
// DAC trial-code register and bit index for the successive-approximation search.
module sar_step_reg
    import sar_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_mid,
    input  logic             decide,
    input  logic             decision,
    output logic [NBITS-1:0] dac,
    output logic             last_bit
);

    localparam int unsigned IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] bit_mask;
    logic [IW-1:0]    idx_q, idx_d;

    // Resolve the current bit and raise the next lower one as the new trial.
    always_comb begin
        bit_mask = NBITS'(1) << idx_q;
        dac_d    = dac_q;
        idx_d    = idx_q;
        if (load_mid) begin
            dac_d = NBITS'(midscale(NBITS));
            idx_d = IW'(NBITS - 1);
        end else if (decide) begin
            dac_d = (dac_q & ~bit_mask) | (decision ? bit_mask : '0) | (bit_mask >> 1);
            if (idx_q != '0) begin
                idx_d = idx_q - IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_q <= '0;
            idx_q <= '0;
        end else begin
            dac_q <= dac_d;
            idx_q <= idx_d;
        end
    end

    assign dac      = dac_q;
    assign last_bit = (idx_q == '0);

endmodule

// File: rtl/sar12_ctrl.sv
// SAR ADC sequencer: sample, binary search against an external comparator,
// then present the result on DATA followed by a one-cycle CAPT strobe.
module sar12_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NBITS         = NBITS_DEF,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic             CMP,
    input  logic             CMP_RDY,
    input  logic             ERR_CLR,
    output logic             SAMPLE,
    output logic             CMP_EN,
    output logic [NBITS-1:0] DAC,
    output logic [NBITS-1:0] DATA,
    output logic             CAPT,
    output logic             BUSY,
    output logic             ERR
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(SAMPLE_CYCLES + 1);

    sar_state_t       state_q, state_d;
    logic [SW-1:0]    samp_cnt_q, samp_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             sample_q, sample_d;
    logic             cmp_en_q, cmp_en_d;
    logic             capt_q, capt_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [NBITS-1:0] data_q, data_d;

    logic             load_mid;
    logic             decide;
    logic             decision;
    logic             err_set;
    logic             last_bit;
    logic [NBITS-1:0] dac;

    sar_step_reg #(
        .NBITS (NBITS)
    ) u_step (
        .clk      (CK),
        .rst_n    (RN),
        .load_mid (load_mid),
        .decide   (decide),
        .decision (decision),
        .dac      (dac),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        data_d     = data_q;
        load_mid   = 1'b0;
        decide     = 1'b0;
        decision   = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = SAMP;
                    load_mid   = 1'b1;
                    samp_cnt_d = '0;
                end
            end
            SAMP: begin
                if (samp_cnt_q == SW'(SAMPLE_CYCLES - 1)) begin
                    state_d = SETTLE;
                end else begin
                    samp_cnt_d = samp_cnt_q + SW'(1);
                end
            end
            SETTLE: begin
                state_d   = COMPARE;
                tmo_cnt_d = '0;
            end
            COMPARE: begin
                // A late decision still wins over the timeout in the last cycle.
                if (CMP_RDY) begin
                    decide   = 1'b1;
                    decision = CMP;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    decide  = 1'b1;
                    err_set = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                if (decide) begin
                    if (last_bit) begin
                        state_d = DONE1;
                        data_d  = (dac & ~NBITS'(1)) | NBITS'(decision);
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            DONE1:   state_d = DONE2;
            DONE2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered so they are all flop-driven.
        sample_d = (state_d == SAMP);
        cmp_en_d = (state_d == COMPARE);
        capt_d   = (state_d == DONE2);
        busy_d   = (state_d != IDLE);
        err_d    = err_set | (err_q & ~ERR_CLR);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            sample_q   <= 1'b0;
            cmp_en_q   <= 1'b0;
            capt_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            sample_q   <= sample_d;
            cmp_en_q   <= cmp_en_d;
            capt_q     <= capt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    assign SAMPLE = sample_q;
    assign CMP_EN = cmp_en_q;
    assign DAC    = dac;
    assign DATA   = data_q;
    assign CAPT   = capt_q;
    assign BUSY   = busy_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_sar12_ctrl.sv
// Bench for sar12_ctrl: per-cycle expected traces built from the SAR algorithm.
module tb_sar12_ctrl;

    localparam int SC   = 2;
    localparam int TMO  = 15;
    localparam int MAXT = 512;

    logic        CK, RN, START, CMP, CMP_RDY, ERR_CLR;
    logic        SAMPLE, CMP_EN, CAPT, BUSY, ERR;
    logic [11:0] DAC, DATA;
    logic [11:0] tvin;

    sar12_ctrl #(.NBITS(12), .SAMPLE_CYCLES(SC), .TIMEOUT(TMO)) dut (
        .CK(CK), .RN(RN), .START(START), .CMP(CMP), .CMP_RDY(CMP_RDY),
        .ERR_CLR(ERR_CLR), .SAMPLE(SAMPLE), .CMP_EN(CMP_EN), .DAC(DAC),
        .DATA(DATA), .CAPT(CAPT), .BUSY(BUSY), .ERR(ERR)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Ideal comparator against the bench's analog input.
    assign CMP = (tvin >= DAC);

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] e_dac [MAXT];
    logic [11:0] e_data[MAXT];
    logic        e_busy[MAXT], e_sample[MAXT], e_cmpen[MAXT], e_capt[MAXT];
    logic        e_err [MAXT], e_set[MAXT];
    logic        d_rdy [MAXT], d_clr[MAXT], d_start[MAXT];
    logic [11:0] d_vin [MAXT];
    int          g_wait[12];
    int          trace_len, g_to_cyc;
    logic [11:0] m_data;
    logic        m_err;
    bit          tracking = 1'b0;
    int          cyc = 0;
    int          capt_count, capt_cyc;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CK) begin
        if (tracking) begin
            chk("BUSY",   12'(BUSY),   12'(e_busy[cyc]));
            chk("SAMPLE", 12'(SAMPLE), 12'(e_sample[cyc]));
            chk("CMP_EN", 12'(CMP_EN), 12'(e_cmpen[cyc]));
            chk("CAPT",   12'(CAPT),   12'(e_capt[cyc]));
            chk("ERR",    12'(ERR),    12'(e_err[cyc]));
            chk("DAC",    DAC,         e_dac[cyc]);
            chk("DATA",   DATA,        e_data[cyc]);
            if (CAPT) begin
                capt_count++;
                capt_cyc = cyc;
            end
        end
    end

    task automatic clear_trace();
        for (int i = 0; i < MAXT; i++) begin
            d_rdy[i] = 1'b0; d_clr[i] = 1'b0; d_start[i] = 1'b0;
            e_set[i] = 1'b0; e_err[i] = 1'b0; d_vin[i] = '0;
        end
        for (int b = 0; b < 12; b++) g_wait[b] = 1;
        trace_len = 0;
    endtask

    task automatic set_cyc(input int t, input logic b, input logic s, input logic c,
                           input logic k, input logic [11:0] dv, input logic [11:0] da,
                           input logic [11:0] vin);
        e_busy[t] = b; e_sample[t] = s; e_cmpen[t] = c; e_capt[t] = k;
        e_dac[t] = dv; e_data[t] = da; d_vin[t] = vin;
    endtask

    // One conversion: sample, then per bit one settle cycle plus the compare wait.
    task automatic add_conv(input logic [11:0] vin, input int base, output int idle_t);
        int t, n;
        bit to;
        logic [11:0] code, trial, one;
        one = 12'h001;
        t = base + 1;
        for (int s = 0; s < SC; s++) begin
            set_cyc(t, 1, 1, 0, 0, 12'h800, m_data, vin); t++;
        end
        code = '0;
        for (int b = 11; b >= 0; b--) begin
            trial = code | (one << b);
            set_cyc(t, 1, 0, 0, 0, trial, m_data, vin); t++;
            to = (g_wait[b] == 0);
            n  = to ? TMO : g_wait[b];
            for (int k = 1; k <= n; k++) begin
                set_cyc(t, 1, 0, 1, 0, trial, m_data, vin);
                if (k == n) begin
                    if (to) begin e_set[t] = 1'b1; g_to_cyc = t; end
                    else d_rdy[t] = 1'b1;
                end
                t++;
            end
            if (!to && vin >= trial) code = code | (one << b);
        end
        m_data = code;
        set_cyc(t, 1, 0, 0, 0, code, code, vin); t++;
        set_cyc(t, 1, 0, 0, 1, code, code, vin); t++;
        set_cyc(t, 0, 0, 0, 0, code, code, vin);
        idle_t    = t;
        trace_len = t;
    endtask

    task automatic compute_err();
        e_err[0] = m_err;
        for (int t = 0; t < trace_len; t++)
            e_err[t+1] = e_set[t] | (e_err[t] & ~d_clr[t]);
        m_err = e_err[trace_len];
    endtask

    task automatic run_trace();
        capt_count = 0;
        capt_cyc   = -1;
        @(posedge CK); #1;
        START = 1'b1; CMP_RDY = 1'b0; ERR_CLR = 1'b0; tvin = d_vin[1]; cyc = 0;
        for (int t = 1; t <= trace_len; t++) begin
            @(posedge CK); #1;
            cyc = t; tracking = 1'b1;
            START = d_start[t]; CMP_RDY = d_rdy[t]; ERR_CLR = d_clr[t]; tvin = d_vin[t];
        end
        @(posedge CK); #1;
        tracking = 1'b0;
        START = 1'b0; CMP_RDY = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic single(input logic [11:0] vin);
        int it;
        add_conv(vin, 0, it);
        compute_err();
        run_trace();
    endtask

    initial begin
        int t1, t2;
        RN = 1'b0; START = 1'b0; CMP_RDY = 1'b0; ERR_CLR = 1'b0; tvin = '0;
        m_data = '0; m_err = 1'b0;
        #3;
        chk("RST_SAMPLE", 12'(SAMPLE), 12'h0);
        chk("RST_CMP_EN", 12'(CMP_EN), 12'h0);
        chk("RST_BUSY",   12'(BUSY),   12'h0);
        chk("RST_CAPT",   12'(CAPT),   12'h0);
        chk("RST_ERR",    12'(ERR),    12'h0);
        chk("RST_DAC",    DAC,         12'h000);
        chk("RST_DATA",   DATA,        12'h000);
        #20 RN = 1'b1;

        // Basic conversion with an immediately ready comparator.
        clear_trace(); single(12'hA5C);
        chk("A5C_DATA", DATA, 12'hA5C);
        chk("A5C_CAPT_CYC", 12'(capt_cyc), 12'd28);
        chk("A5C_CAPT_CNT", 12'(capt_count), 12'd1);

        // Full-scale and zero inputs.
        clear_trace(); single(12'hFFF);
        chk("FFF_DATA", DATA, 12'hFFF);
        clear_trace(); single(12'h000);
        chk("000_DATA", DATA, 12'h000);

        // Comparator ready only in the 4th compare cycle.
        clear_trace();
        for (int b = 0; b < 12; b++) g_wait[b] = 4;
        single(12'h3A7);
        chk("3A7_DATA", DATA, 12'h3A7);
        chk("3A7_CAPT_CYC", 12'(capt_cyc), 12'd64);
        chk("3A7_ERR", 12'(ERR), 12'h0);

        // Bit 7 never gets a decision: forced to 0, ERR set.
        clear_trace(); g_wait[7] = 0; single(12'hFFF);
        chk("TMO_DATA", DATA, 12'hF7F);
        chk("TMO_ERR", 12'(ERR), 12'h1);
        chk("TMO_CAPT_CYC", 12'(capt_cyc), 12'd42);
        @(posedge CK); #1 ERR_CLR = 1'b1;
        @(posedge CK); #1 ERR_CLR = 1'b0;
        @(negedge CK);
        chk("ERRCLR_ERR", 12'(ERR), 12'h0);
        m_err = 1'b0;

        // Clear request coinciding with a second timeout: the set wins.
        clear_trace(); g_wait[7] = 0;
        add_conv(12'hFFF, 0, t1);
        d_clr[g_to_cyc] = 1'b1;
        compute_err();
        run_trace();
        chk("SETWIN_ERR", 12'(ERR), 12'h1);

        // START pulses while busy, including in the capture cycle, are ignored.
        clear_trace();
        add_conv(12'h6C3, 0, t1);
        d_start[5] = 1'b1; d_start[20] = 1'b1; d_start[28] = 1'b1;
        compute_err();
        run_trace();
        chk("IGN_CAPT_CNT", 12'(capt_count), 12'd1);
        chk("IGN_DATA", DATA, 12'h6C3);

        // Reset during the bit-5 compare abandons the conversion.
        tvin = 12'h5A5; CMP_RDY = 1'b1;
        @(posedge CK); #1 START = 1'b1;
        @(posedge CK); #1 START = 1'b0;
        repeat (15) @(posedge CK);
        #3;
        chk("MID_DAC", DAC, 12'h5A0);
        chk("MID_BUSY", 12'(BUSY), 12'h1);
        RN = 1'b0;
        #1;
        chk("ARST_SAMPLE", 12'(SAMPLE), 12'h0);
        chk("ARST_CMP_EN", 12'(CMP_EN), 12'h0);
        chk("ARST_BUSY",   12'(BUSY),   12'h0);
        chk("ARST_CAPT",   12'(CAPT),   12'h0);
        chk("ARST_ERR",    12'(ERR),    12'h0);
        chk("ARST_DAC",    DAC,         12'h000);
        chk("ARST_DATA",   DATA,        12'h000);
        CMP_RDY = 1'b0;
        @(posedge CK); #1 RN = 1'b1;
        m_data = '0; m_err = 1'b0;
        clear_trace(); single(12'h5A5);
        chk("POSTRST_DATA", DATA, 12'h5A5);

        // START held high: back-to-back conversions.
        clear_trace();
        add_conv(12'h123, 0, t1);
        add_conv(12'hEDC, t1, t2);
        for (int i = 1; i < t2; i++) d_start[i] = 1'b1;
        compute_err();
        run_trace();
        chk("B2B_CAPT_CNT", 12'(capt_count), 12'd2);
        chk("B2B_CAPT_CYC", 12'(capt_cyc), 12'd57);
        chk("B2B_DATA", DATA, 12'hEDC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar12_ctrl.md
Name: sar12_ctrl

Overview:
- 12-bit successive-approximation control logic for the SAR ADC built from the SUN_TR SKY130 cell set.
- Runs sample, then a binary search against an external comparator, and drives the trial code onto the CDAC.
- Presents the final code on DATA with a one-cycle CAPT strobe. CAPT is the CK of the downstream 12-bit tristate output register; DATA feeds its D inputs.

Parameters:
- NBITS, 12, conversion resolution (bits).
- SAMPLE_CYCLES, 2, number of cycles SAMPLE is held high. Must be >= 1.
- TIMEOUT, 15, maximum COMPARE cycles spent waiting for CMP_RDY before forcing a decision. Must be >= 1.

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  reset, asynchronous, active-low.
- START  in  1  conversion request, level; sampled only in IDLE.
- CMP  in  1  comparator decision; 1 = input >= DAC trial code.
- CMP_RDY  in  1  comparator decision valid.
- ERR_CLR  in  1  clears ERR.
- SAMPLE  out  1  CDAC track phase.
- CMP_EN  out  1  comparator enable.
- DAC  out  NBITS  trial code to the CDAC switches.
- DATA  out  NBITS  last completed conversion result.
- CAPT  out  1  capture strobe to the downstream register.
- BUSY  out  1  conversion in progress.
- ERR  out  1  sticky comparator-timeout flag.

Behaviour:
- Reset (RN=0, asynchronous): state IDLE; SAMPLE, CMP_EN, CAPT, BUSY, ERR = 0; DAC, DATA = 0. Takes effect immediately, including mid-conversion. The conversion is abandoned and DATA is cleared.
- All outputs are registered. States: IDLE, SAMP, SETTLE, COMPARE, DONE1, DONE2.
- IDLE: BUSY=0. START=1 at an edge moves to SAMP. On the same edge: BUSY=1, SAMPLE=1, DAC=1<<(NBITS-1), bit index i=NBITS-1.
- SAMP: held exactly SAMPLE_CYCLES cycles, then SETTLE with SAMPLE=0.
- SETTLE: one cycle, CMP_EN=0, lets the DAC settle. Next state is COMPARE with CMP_EN=1 and the timeout counter cleared.
- COMPARE: CMP_EN=1. CMP_RDY and CMP are sampled only in this state.
  - On CMP_RDY=1: DAC[i] takes the value of CMP. If i>0, also set DAC[i-1]=1, decrement i, and go to SETTLE. If i=0, go to DONE1.
  - If CMP_RDY is still 0 after TIMEOUT COMPARE cycles: DAC[i]=0, ERR=1, then advance exactly as on a decision.
  - Timeout counter width is clog2(TIMEOUT+1). Index width is clog2(NBITS).
- DONE1: CMP_EN=0. DATA is loaded with the final DAC value on entry.
- DONE2: CAPT=1 for exactly this one cycle. DATA is therefore stable one full cycle before CAPT rises. Then go to IDLE with BUSY=0.
- DATA holds its value until the next DONE1 (or reset). DAC holds its final code in IDLE.
- START while BUSY=1 is ignored. START still high in IDLE restarts immediately, so BUSY is low for exactly one cycle between back-to-back conversions.
- ERR is sticky. ERR_CLR=1 clears it. If a timeout and ERR_CLR occur in the same cycle, the set wins.
- Latency with CMP_RDY asserted in the first COMPARE cycle: CAPT is high in cycle SAMPLE_CYCLES+2*NBITS+2 after the START-sampling edge (28 for the defaults). Each extra COMPARE wait cycle adds 1.

Decomposition:
- Package sar_pkg holds:
  - state enum sar_state_t {IDLE, SAMP, SETTLE, COMPARE, DONE1, DONE2};
  - default NBITS constant;
  - helper function for the midscale code.
- One natural sub-module: sar_step_reg, the DAC/bit-index datapath.
  - Inputs: load_mid, decide, decision.
  - Outputs: DAC, last_bit.
- The FSM, timeout counter and output flops stay in sar12_ctrl.

Test Plan:
- Comparator model CMP=(VIN>=DAC), CMP_RDY tied 1, VIN=0xA5C, START pulse -> DATA=0xA5C. CAPT is a single pulse in cycle 28. DATA is stable the cycle before. ERR=0. BUSY high for cycles 1..28.
- VIN=0xFFF, then VIN=0x000 -> DATA=0xFFF, then 0x000. DAC sequence starts at 0x800, and the second trial is 0xC00 or 0x400 respectively.
- CMP_RDY asserted only in the 4th COMPARE cycle of every bit, VIN=0x3A7 -> DATA=0x3A7, CAPT in cycle 2+12*5+2=64, ERR=0.
- CMP_RDY held 0 for bit 7 only, VIN=0xFFF -> after 15 COMPARE cycles bit 7 is forced to 0. DATA=0xF7F and ERR=1 persists. ERR_CLR pulse -> ERR=0. ERR_CLR in the same cycle as a second timeout -> ERR=1.
- START pulses during BUSY are ignored (exactly one CAPT). RN low at bit 5 -> all outputs 0 asynchronously, DATA=0. After release, START converts correctly.
- START held high continuously -> back-to-back conversions, BUSY low exactly one cycle between them, one CAPT per conversion.
